// File: rtl/gps_sv_frame_assembler_if.sv
// Byte-write stream from the GPS time/state-vector command receiver.
// The receiver is master; the frame assembler is slave.
interface gps_sv_frame_assembler_if;
    logic       tlm_wclk;
    logic [4:0] tlm_waddr;
    logic [7:0] param_byte;

    modport master (output tlm_wclk, output tlm_waddr, output param_byte);
    modport slave  (input  tlm_wclk, input  tlm_waddr, input  param_byte);
endinterface

// File: rtl/gps_sv_frame_assembler.sv
// Assembles 32-byte GPS parameter frames with an XOR checksum and publishes good frames
// through a double-buffered read port, plus decoded GPS week / time-of-week.
module gps_sv_frame_assembler #(
    parameter int unsigned FRAME_BYTES = 32,
    parameter logic [4:0]  ADDR_BASE   = 5'd1,
    parameter int unsigned TIMEOUT_CYC = 20000
) (
    input  logic                           clk,
    input  logic                           reset,
    gps_sv_frame_assembler_if.slave        wr,
    input  logic [4:0]                     rd_addr,
    output logic [7:0]                     rd_data,
    output logic                           frame_valid,
    output logic                           chk_err,
    output logic                           seq_err,
    output logic                           tmo_err,
    output logic [15:0]                    gps_week,
    output logic [31:0]                    gps_tow,
    output logic [15:0]                    frame_cnt
);

    localparam logic [4:0]  LAST_IDX = 5'(FRAME_BYTES - 1);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK
    } state_t;

    state_t                  state_q, state_d;
    logic                    wclk_prev_q, wclk_prev_d;
    logic [4:0]              waddr_prev_q, waddr_prev_d;
    logic [1:0][31:0][7:0]   mem_q, mem_d;
    logic                    wr_bank_q, wr_bank_d;
    logic [7:0]              xacc_q, xacc_d;
    logic [7:0]              chk_q, chk_d;
    logic [4:0]              exp_q, exp_d;
    logic [TW-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic [7:0]              rd_data_q, rd_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    chk_err_q, chk_err_d;
    logic                    seq_err_q, seq_err_d;
    logic                    tmo_err_q, tmo_err_d;
    logic [15:0]             gps_week_q, gps_week_d;
    logic [31:0]             gps_tow_q, gps_tow_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;

    logic       we;
    logic [4:0] idx;
    logic       pub_bank;

    // A write is a strobe rising edge, or an address change while the strobe is held high.
    assign we       = wr.tlm_wclk && (!wclk_prev_q || (wr.tlm_waddr != waddr_prev_q));
    assign idx      = wr.tlm_waddr - ADDR_BASE;
    assign pub_bank = ~wr_bank_q;

    always_comb begin
        state_d       = state_q;
        wclk_prev_d   = wr.tlm_wclk;
        waddr_prev_d  = wr.tlm_waddr;
        mem_d         = mem_q;
        wr_bank_d     = wr_bank_q;
        xacc_d        = xacc_q;
        chk_d         = chk_q;
        exp_d         = exp_q;
        tmo_cnt_d     = tmo_cnt_q;
        rd_data_d     = mem_q[pub_bank][rd_addr];
        frame_valid_d = 1'b0;
        chk_err_d     = 1'b0;
        seq_err_d     = 1'b0;
        tmo_err_d     = 1'b0;
        gps_week_d    = gps_week_q;
        gps_tow_d     = gps_tow_q;
        frame_cnt_d   = frame_cnt_q;

        if (frame_valid_q) begin
            gps_week_d = {mem_q[pub_bank][0], mem_q[pub_bank][1]};
            gps_tow_d  = {mem_q[pub_bank][2], mem_q[pub_bank][3],
                          mem_q[pub_bank][4], mem_q[pub_bank][5]};
        end

        case (state_q)
            S_IDLE: begin
            end
            S_COLLECT: begin
                if (we) begin
                    tmo_cnt_d = '0;
                    if (idx == exp_q) begin
                        mem_d[wr_bank_q][idx] = wr.param_byte;
                        exp_d = exp_q + 5'd1;
                        if (idx == LAST_IDX) begin
                            chk_d   = wr.param_byte;
                            state_d = S_CHECK;
                        end else begin
                            xacc_d = xacc_q ^ wr.param_byte;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if (xacc_q == chk_q) begin
                    wr_bank_d     = pub_bank;
                    frame_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    chk_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start is shared by IDLE and CHECK; after a swap byte 0 lands in the new write bank.
        if ((state_q == S_IDLE || state_q == S_CHECK) && we && (idx == '0)) begin
            mem_d[wr_bank_d][0] = wr.param_byte;
            xacc_d              = wr.param_byte;
            exp_d               = 5'd1;
            tmo_cnt_d           = '0;
            state_d             = S_COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wclk_prev_q   <= 1'b0;
            waddr_prev_q  <= '0;
            mem_q         <= '0;
            wr_bank_q     <= 1'b0;
            xacc_q        <= '0;
            chk_q         <= '0;
            exp_q         <= '0;
            tmo_cnt_q     <= '0;
            rd_data_q     <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            tmo_err_q     <= 1'b0;
            gps_week_q    <= '0;
            gps_tow_q     <= '0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wclk_prev_q   <= wclk_prev_d;
            waddr_prev_q  <= waddr_prev_d;
            mem_q         <= mem_d;
            wr_bank_q     <= wr_bank_d;
            xacc_q        <= xacc_d;
            chk_q         <= chk_d;
            exp_q         <= exp_d;
            tmo_cnt_q     <= tmo_cnt_d;
            rd_data_q     <= rd_data_d;
            frame_valid_q <= frame_valid_d;
            chk_err_q     <= chk_err_d;
            seq_err_q     <= seq_err_d;
            tmo_err_q     <= tmo_err_d;
            gps_week_q    <= gps_week_d;
            gps_tow_q     <= gps_tow_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign chk_err     = chk_err_q;
    assign seq_err     = seq_err_q;
    assign tmo_err     = tmo_err_q;
    assign gps_week    = gps_week_q;
    assign gps_tow     = gps_tow_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_gps_sv_frame_assembler.sv
// Scoreboard bench for gps_sv_frame_assembler: expected pulses are queued by the stimulus
// and consumed by an independent monitor; published data is checked through the read port.
module tb_gps_sv_frame_assembler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        frame_valid, chk_err, seq_err, tmo_err;
    logic [15:0] gps_week, frame_cnt;
    logic [31:0] gps_tow;

    gps_sv_frame_assembler_if wr_if();

    gps_sv_frame_assembler #(
        .FRAME_BYTES(32),
        .ADDR_BASE  (5'd1),
        .TIMEOUT_CYC(20000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_if.slave),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_valid(frame_valid),
        .chk_err    (chk_err),
        .seq_err    (seq_err),
        .tmo_err    (tmo_err),
        .gps_week   (gps_week),
        .gps_tow    (gps_tow),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    localparam int K_VALID = 1;
    localparam int K_CHK   = 2;
    localparam int K_SEQ   = 3;
    localparam int K_TMO   = 4;

    typedef struct {
        int kind;
        int cnt;
        int cyc;
    } ev_t;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    int         model_cnt = 0;
    logic [7:0] fr [32];
    int         mon_kind;
    ev_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every status pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (frame_valid | chk_err | seq_err | tmo_err) begin
            mon_kind = frame_valid ? K_VALID : chk_err ? K_CHK : seq_err ? K_SEQ : K_TMO;
            if ($countones({frame_valid, chk_err, seq_err, tmo_err}) > 1) mon_kind = 9;
            if (sb.size() == 0) begin
                check("unexpected_pulse", mon_kind, 0);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", mon_kind, mon_e.kind);
                check("pulse_frame_cnt", frame_cnt, mon_e.cnt);
                check("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic expect_ev(input int kind, input int cyc_at);
        ev_t e;
        if (kind == K_VALID) model_cnt++;
        e.kind = kind;
        e.cnt  = model_cnt;
        e.cyc  = cyc_at;
        sb.push_back(e);
    endtask

    task automatic wbyte(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_if.tlm_wclk   = 1'b1;
        wr_if.tlm_waddr  = a;
        wr_if.param_byte = d;
        last_cyc = cyc;
        @(posedge clk); #1;
        wr_if.tlm_wclk = 1'b0;
    endtask

    task automatic hbyte(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_if.tlm_wclk   = 1'b1;
        wr_if.tlm_waddr  = a;
        wr_if.param_byte = d;
        last_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic make_frame(input logic [7:0] base, input bit bad);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 31; i++) begin
            fr[i] = base + 8'(i);
            x = x ^ fr[i];
        end
        fr[31] = bad ? 8'h00 : x;
    endtask

    task automatic send_frame(input bit held, input int kind);
        for (int i = 0; i < 32; i++) begin
            if (held) hbyte(5'(i + 1), fr[i]);
            else      wbyte(5'(i + 1), fr[i]);
        end
        #1 wr_if.tlm_wclk = 1'b0;
        expect_ev(kind, last_cyc + 2);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check(name, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic rd_check(input logic [4:0] a, input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    initial begin
        wr_if.tlm_wclk   = 1'b0;
        wr_if.tlm_waddr  = '0;
        wr_if.param_byte = '0;
        rd_addr          = '0;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_gps_week", gps_week, 0);
        check("rst_gps_tow", gps_tow, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_pulses", {frame_valid, chk_err, seq_err, tmo_err}, 0);

        // Good frame 0x00..0x1E, checksum 0x1F
        make_frame(8'h00, 1'b0);
        send_frame(1'b0, K_VALID);
        wait_drain(10, "good_frame_missing");
        @(negedge clk);
        check("good_gps_week", gps_week, 32'h0001);
        check("good_gps_tow", gps_tow, 32'h0203_0405);
        check("good_frame_cnt", frame_cnt, 1);
        rd_check(5'd7, 8'h07, "good_rd7");
        rd_check(5'd31, 8'h1F, "good_rd31");

        // Bad checksum: dropped, published frame untouched
        make_frame(8'h00, 1'b1);
        send_frame(1'b0, K_CHK);
        wait_drain(10, "chk_err_missing");
        rd_check(5'd7, 8'h07, "bad_rd7");
        rd_check(5'd31, 8'h1F, "bad_rd31");
        check("bad_frame_cnt", frame_cnt, 1);

        // Held strobe, address stepping
        make_frame(8'h40, 1'b0);
        send_frame(1'b1, K_VALID);
        wait_drain(10, "held_frame_missing");
        @(negedge clk);
        check("held_gps_week", gps_week, 32'h4041);
        check("held_gps_tow", gps_tow, 32'h4243_4445);
        rd_check(5'd7, 8'h47, "held_rd7");
        rd_check(5'd31, 8'h5F, "held_rd31");

        // Sequence error: address 6 skipped
        for (int i = 1; i <= 5; i++) wbyte(5'(i), 8'(8'h10 + i));
        wbyte(5'd7, 8'h17);
        expect_ev(K_SEQ, last_cyc + 1);
        wait_drain(10, "seq_err_missing");
        make_frame(8'h00, 1'b0);
        send_frame(1'b0, K_VALID);
        wait_drain(10, "post_seq_frame_missing");
        @(negedge clk);
        check("post_seq_gps_week", gps_week, 32'h0001);
        rd_check(5'd7, 8'h07, "post_seq_rd7");

        // Timeout after 10 bytes
        for (int i = 0; i < 10; i++) wbyte(5'(i + 1), 8'(8'h60 + i));
        expect_ev(K_TMO, last_cyc + 20001);
        wait_drain(21000, "tmo_err_missing");
        rd_check(5'd7, 8'h07, "post_tmo_rd7");
        check("post_tmo_frame_cnt", frame_cnt, 3);

        // Reset in the middle of a frame
        for (int i = 0; i < 15; i++) wbyte(5'(i + 1), 8'(8'h70 + i));
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_gps_week", gps_week, 0);
        rd_check(5'd7, 8'h00, "midrst_rd7");
        make_frame(8'h40, 1'b0);
        send_frame(1'b0, K_VALID);
        wait_drain(10, "post_rst_frame_missing");
        @(negedge clk);
        check("post_rst_frame_cnt", frame_cnt, 1);
        check("post_rst_gps_week", gps_week, 32'h4041);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
